// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start bit, serializer data phase, optional parity, stop bit(s).
// Define UART_TX_2STOP_EN to add a second stop bit (STOP2); the accept window then moves to STOP2.
module uart_tx_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned WDOG_CYC   = 10
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_done,
    output logic [DATA_WIDTH-1:0] ser_p_data,
    output logic                  ser_en,
    output logic [1:0]            mux_sel,
    output logic                  par_bit,
    output logic                  busy,
    output logic                  frame_err
);

    localparam int unsigned CW = $clog2(WDOG_CYC + 1);
    localparam logic [CW-1:0] WDOG_LAST = CW'(WDOG_CYC - 1);

`ifdef UART_TX_2STOP_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, STOP2} state_t;
    localparam state_t LAST_STOP = STOP2;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam state_t LAST_STOP = STOP;
`endif

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  ferr_q, ferr_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            cnt_q     <= '0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            cnt_q     <= cnt_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        cnt_d     = '0;
        ferr_d    = 1'b0;

        case (state_q)
            IDLE:   state_d = IDLE;
            START:  state_d = DATA;
            DATA: begin
                // Watchdog: the WDOG_CYC-th DATA cycle without ser_done aborts the frame.
                cnt_d = cnt_q + 1'b1;
                if (ser_done) begin
                    state_d = par_en_q ? PARITY : STOP;
                end else if (cnt_q == WDOG_LAST) begin
                    state_d = STOP;
                    ferr_d  = 1'b1;
                end
            end
            PARITY: state_d = STOP;
`ifdef UART_TX_2STOP_EN
            STOP:   state_d = STOP2;
            STOP2:  state_d = IDLE;
`else
            STOP:   state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase

        // Accepting in the last stop cycle gives back-to-back frames with no idle gap.
        if (Data_Valid && (state_q == IDLE || state_q == LAST_STOP)) begin
            state_d   = START;
            data_d    = P_DATA;
            par_en_d  = PAR_EN;
            par_bit_d = (^P_DATA) ^ PAR_TYP;
        end
    end

    always_comb begin
        mux_sel = 2'b01;
        ser_en  = 1'b0;
        busy    = (state_q != IDLE);
        case (state_q)
            START: begin
                mux_sel = 2'b00;
                ser_en  = 1'b1;
            end
            DATA:    mux_sel = 2'b10;
            PARITY:  mux_sel = 2'b11;
            default: mux_sel = 2'b01;
        endcase
    end

    assign ser_p_data = data_q;
    assign par_bit    = par_bit_q;
    assign frame_err  = ferr_q;

endmodule
